axis_byte_block_packer: RTL and testbench
=========================================

Name: axis_byte_block_packer

Overview:
- Upstream feeder for the AES encrypt stream slave. It takes the 8-bit AXI-Stream byte flow from the UART receive path and packs 16 bytes into one 128-bit AES block with tlast.
- A short final block is padded, using zero or PKCS#7 padding.
- The output drives the AES core's s00_axis_* port directly. It honours tready backpressure, including the core's "key not valid" stall.

Parameters:
- PAD_MODE, 1, padding mode: 0 = zero-fill short final block; 1 = PKCS#7 (pad value = number of pad bytes, full extra block when message is a multiple of 16).
- CNT_W, 16, width of the emitted-block counter.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  8  input byte.
- s_axis_tvalid  in  1  byte valid.
- s_axis_tready  out  1  packer can accept a byte.
- s_axis_tlast  in  1  last byte of message.
- m_axis_tdata  out  128  packed AES block.
- m_axis_tvalid  out  1  block valid.
- m_axis_tready  in  1  downstream accepts block.
- m_axis_tlast  out  1  final block of message.
- byte_idx  out  4  bytes held in current partial block (0-15).
- blocks_out  out  CNT_W  blocks handed off since reset; wraps modulo 2^CNT_W.

Behaviour:
- Reset (aresetn low, async):
  - State = FILL; byte_idx = 0; assembly register = 0.
  - m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0, blocks_out = 0.
  - A partial block held at reset is discarded.
  - s_axis_tready is 0 while in reset.
- Byte order:
  - The first byte of a block lands in tdata[127:120]; byte n lands in tdata[127-8n -: 8]. This is AES big-endian state order.
- Output register:
  - A single register holds tdata, tvalid and tlast.
  - "out_free" = !m_axis_tvalid || m_axis_tready.
  - On an m handshake with no new load, tvalid drops the next cycle.
  - tdata and tlast are held stable while tvalid=1 and tready=0.
- s_axis_tready = (state==FILL) && out_free. Input stalls while the output block is pending and unaccepted.
- States:
  - FILL, on byte handshake without tlast:
    - byte written at byte_idx.
    - If byte_idx==15: the complete block is loaded to the output with tlast=0 and byte_idx wraps to 0.
    - Otherwise byte_idx increments.
  - FILL, on byte handshake with tlast at byte_idx=k (k = 0..15, k+1 bytes valid):
    - If k<15: positions k+1..15 are filled with 0x00 (PAD_MODE=0) or with the value (15-k) (PAD_MODE=1). The block is loaded with tlast=1 and byte_idx goes to 0.
    - If k==15 and PAD_MODE=0: the block is loaded with tlast=1.
    - If k==15 and PAD_MODE=1: the block is loaded with tlast=0 and the state goes to EXTRA.
  - EXTRA:
    - s_axis_tready=0.
    - When out_free, load a block of sixteen 0x10 bytes with tlast=1 and return to FILL.
- Latency: a block is valid on m_axis the cycle after the handshake of its completing byte (or after out_free in EXTRA).
- Throughput:
  - One byte per cycle when downstream is ready.
  - Back-to-back blocks are legal: the completing byte may be accepted in the same cycle the previous block handshakes.
- blocks_out increments by 1 on each m_axis handshake.
- A tlast on an otherwise empty message is impossible, since the tlast byte is itself data. No empty-message case exists.
- No tdata/tlast change on the output while tvalid=1 and tready=0, which meets the AXIS stability rule.

Test Plan:
1. Reset, m_axis_tready=1, send 16 bytes 0x00..0x0F with tlast on the last byte -> one block:
   - PAD_MODE=0: m_axis_tdata=0x000102030405060708090A0B0C0D0E0F, tlast=1, blocks_out=1.
   - PAD_MODE=1: same block with tlast=0, then block 0x1010...10 with tlast=1, blocks_out=2.
2. PAD_MODE=1, send 5 bytes 0xA1..0xA5 with tlast on 0xA5 -> tdata=0xA1A2A3A4A5 followed by eleven 0x0B bytes, tlast=1, byte_idx returns to 0.
3. PAD_MODE=0, send 3 bytes 0x11,0x22,0x33 with tlast -> tdata=0x112233 followed by thirteen 0x00 bytes, tlast=1.
4. Send 32 bytes continuously with m_axis_tready held 0 for 10 cycles after the first block is valid:
   - s_axis_tready=0 throughout the stall.
   - First block tdata remains stable.
   - After release, both blocks are delivered in order with no byte loss.
5. Continuous 48 bytes with tready=1 -> three blocks on consecutive 16-cycle boundaries, and s_axis_tready never drops.
6. Assert aresetn low after 7 bytes of a block -> all outputs return to reset values immediately. The next 16 bytes form a fresh block starting at tdata[127:120].

Source files
------------

// File: rtl/axis_byte_block_packer.sv
// axis_byte_block_packer: packs an 8-bit AXI-Stream byte flow into 128-bit AES blocks with zero or PKCS#7 padding.
// Ports:
//   aclk, aresetn                       clock, asynchronous active-low reset
//   s_axis_tdata/tvalid/tready/tlast    byte input stream (tlast marks last byte of a message)
//   m_axis_tdata/tvalid/tready/tlast    128-bit block output, first byte in tdata[127:120]
//   byte_idx                            bytes held in the current partial block
//   blocks_out                          blocks handed off since reset (wraps)
module axis_byte_block_packer #(
  parameter int PAD_MODE = 1,
  parameter int CNT_W    = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [7:0]       s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  output logic [127:0]     m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic [3:0]       byte_idx,
  output logic [CNT_W-1:0] blocks_out
);
  typedef enum logic {FILL, EXTRA} state_t;
  state_t state, state_nxt;
  logic [127:0] asm_q, asm_nxt, blk, load_data;
  logic [3:0] idx_nxt;
  logic [7:0] pad_val;
  logic out_free, s_hs, load, load_last, full_last;
  assign out_free      = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = aresetn && state == FILL && out_free;
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  assign pad_val       = (PAD_MODE != 0) ? {4'd0, 4'd15 - byte_idx} : 8'd0;
  // A PKCS#7 message ending exactly on a block boundary needs a whole pad block after it.
  assign full_last     = s_axis_tlast && PAD_MODE != 0 && byte_idx == 4'd15;
  // Current block with the incoming byte merged in; on tlast every later position takes the pad byte.
  always_comb begin
    blk = asm_q;
    for (int p = 0; p < 16; p++) begin
      if (4'(p) == byte_idx)
        blk[127-8*p -: 8] = s_axis_tdata;
      else if (4'(p) > byte_idx && s_axis_tlast)
        blk[127-8*p -: 8] = pad_val;
    end
  end
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_data = blk;
    load_last = 1'b0;
    idx_nxt   = byte_idx;
    asm_nxt   = asm_q;
    if (state == EXTRA) begin
      if (out_free) begin
        load      = 1'b1;
        load_data = {16{8'h10}};
        load_last = 1'b1;
        state_nxt = FILL;
      end
    end else if (s_hs) begin
      if (s_axis_tlast || byte_idx == 4'd15) begin
        load      = 1'b1;
        load_last = s_axis_tlast && !full_last;
        idx_nxt   = 4'd0;
        asm_nxt   = '0;
        state_nxt = full_last ? EXTRA : FILL;
      end else begin
        asm_nxt = blk;
        idx_nxt = byte_idx + 4'd1;
      end
    end
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= FILL;
    else          state <= state_nxt;
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      byte_idx      <= '0;
      asm_q         <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      blocks_out    <= '0;
    end else begin
      byte_idx <= idx_nxt;
      asm_q    <= asm_nxt;
      if (m_axis_tvalid && m_axis_tready) blocks_out <= blocks_out + CNT_W'(1);
      if (load) begin
        m_axis_tdata  <= load_data;
        m_axis_tlast  <= load_last;
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axis_byte_block_packer.sv
// tb_axis_byte_block_packer: directed bench for the byte-to-AES-block packer, one zero-pad and one PKCS#7 instance.
module tb_axis_byte_block_packer;
  logic aclk = 1'b0, aresetn = 1'b0;
  logic [7:0]   s_tdata[2];
  logic         s_tvalid[2], s_tready[2], s_tlast[2];
  logic [127:0] m_tdata[2];
  logic         m_tvalid[2], m_tready[2], m_tlast[2];
  logic [3:0]   bidx[2];
  logic [15:0]  bo[2];
  int n_chk = 0, n_pass = 0, cyc = 0;
  int exp_cnt[2];
  logic [128:0] q0[$], q1[$];
  int t0[$];
  typedef struct {
    int d; int n; logic [7:0] base; logic [7:0] step; int nblk;
    logic [127:0] d0; logic l0; logic [127:0] d1; logic l1;
  } vec_t;
  vec_t vt[7];

  always #5 aclk = ~aclk;

  axis_byte_block_packer #(.PAD_MODE(0), .CNT_W(16)) u0 (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata[0]), .s_axis_tvalid(s_tvalid[0]), .s_axis_tready(s_tready[0]), .s_axis_tlast(s_tlast[0]),
    .m_axis_tdata(m_tdata[0]), .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(m_tready[0]), .m_axis_tlast(m_tlast[0]),
    .byte_idx(bidx[0]), .blocks_out(bo[0]));
  axis_byte_block_packer #(.PAD_MODE(1), .CNT_W(16)) u1 (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata[1]), .s_axis_tvalid(s_tvalid[1]), .s_axis_tready(s_tready[1]), .s_axis_tlast(s_tlast[1]),
    .m_axis_tdata(m_tdata[1]), .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(m_tready[1]), .m_axis_tlast(m_tlast[1]),
    .byte_idx(bidx[1]), .blocks_out(bo[1]));

  always @(posedge aclk) cyc <= cyc + 1;
  always @(posedge aclk) begin
    if (aresetn && m_tvalid[0] && m_tready[0]) begin
      q0.push_back({m_tlast[0], m_tdata[0]});
      t0.push_back(cyc);
    end
    if (aresetn && m_tvalid[1] && m_tready[1]) q1.push_back({m_tlast[1], m_tdata[1]});
  end

  task automatic chk(input string nm, input logic [128:0] act, input logic [128:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  function automatic int qsize(input int d);
    return d == 0 ? q0.size() : q1.size();
  endfunction

  function automatic logic [128:0] qget(input int d, input int i);
    return d == 0 ? q0[i] : q1[i];
  endfunction

  task automatic qclear(input int d);
    if (d == 0) begin q0.delete(); t0.delete(); end
    else q1.delete();
  endtask

  task automatic send_msg(input int d, input int n, input logic [7:0] base, input logic [7:0] step,
                          input logic with_last, output int stalls);
    int k;
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge aclk);
      s_tdata[d]  = base + 8'(i) * step;
      s_tvalid[d] = 1'b1;
      s_tlast[d]  = with_last && i == n - 1;
      for (k = 0; k < 200; k++) begin
        #1;
        if (s_tready[d]) break;
        stalls++;
        @(negedge aclk);
      end
      if (k == 200) timeout("send");
      @(posedge aclk);
    end
    @(negedge aclk);
    s_tvalid[d] = 1'b0;
    s_tlast[d]  = 1'b0;
  endtask

  task automatic wait_blocks(input int d, input int n);
    int k;
    for (k = 0; k < 200 && qsize(d) < n; k++) @(negedge aclk);
    if (k == 200) timeout("wait_blocks");
  endtask

  task automatic chk_reset(input string nm);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_valid%0d", nm, d), 129'(m_tvalid[d]), 129'd0);
      chk($sformatf("%s_data%0d", nm, d), {m_tlast[d], m_tdata[d]}, 129'd0);
      chk($sformatf("%s_idx%0d", nm, d), 129'(bidx[d]), 129'd0);
      chk($sformatf("%s_cnt%0d", nm, d), 129'(bo[d]), 129'd0);
      chk($sformatf("%s_srdy%0d", nm, d), 129'(s_tready[d]), 129'd0);
    end
  endtask

  initial begin
    int st, k;
    vt[0] = '{0, 16, 8'h00, 8'h01, 1, 128'h000102030405060708090A0B0C0D0E0F, 1'b1, 128'h0, 1'b0};
    vt[1] = '{1, 16, 8'h00, 8'h01, 2, 128'h000102030405060708090A0B0C0D0E0F, 1'b0,
              128'h10101010101010101010101010101010, 1'b1};
    vt[2] = '{1, 5,  8'hA1, 8'h01, 1, 128'hA1A2A3A4A50B0B0B0B0B0B0B0B0B0B0B, 1'b1, 128'h0, 1'b0};
    vt[3] = '{0, 3,  8'h11, 8'h11, 1, 128'h11223300000000000000000000000000, 1'b1, 128'h0, 1'b0};
    vt[4] = '{1, 15, 8'h30, 8'h01, 1, 128'h303132333435363738393A3B3C3D3E01, 1'b1, 128'h0, 1'b0};
    vt[5] = '{0, 1,  8'hFF, 8'h01, 1, 128'hFF000000000000000000000000000000, 1'b1, 128'h0, 1'b0};
    vt[6] = '{1, 1,  8'h55, 8'h01, 1, 128'h550F0F0F0F0F0F0F0F0F0F0F0F0F0F0F, 1'b1, 128'h0, 1'b0};
    for (int d = 0; d < 2; d++) begin
      s_tdata[d] = '0; s_tvalid[d] = 1'b0; s_tlast[d] = 1'b0; m_tready[d] = 1'b1; exp_cnt[d] = 0;
    end
    repeat (3) @(negedge aclk);
    #1;
    chk_reset("rst");
    @(negedge aclk);
    aresetn = 1'b1;

    for (int i = 0; i < 7; i++) begin
      qclear(vt[i].d);
      send_msg(vt[i].d, vt[i].n, vt[i].base, vt[i].step, 1'b1, st);
      wait_blocks(vt[i].d, vt[i].nblk);
      repeat (3) @(negedge aclk);
      #1;
      exp_cnt[vt[i].d] += vt[i].nblk;
      chk($sformatf("v%0d_nblk", i), 129'(qsize(vt[i].d)), 129'(vt[i].nblk));
      chk($sformatf("v%0d_blk0", i), qget(vt[i].d, 0), {vt[i].l0, vt[i].d0});
      if (vt[i].nblk > 1) chk($sformatf("v%0d_blk1", i), qget(vt[i].d, 1), {vt[i].l1, vt[i].d1});
      chk($sformatf("v%0d_idx", i), 129'(bidx[vt[i].d]), 129'd0);
      chk($sformatf("v%0d_cnt", i), 129'(bo[vt[i].d]), 129'(exp_cnt[vt[i].d]));
    end

    qclear(0);
    @(negedge aclk);
    m_tready[0] = 1'b0;
    fork
      send_msg(0, 32, 8'h00, 8'h01, 1'b1, st);
      begin
        for (k = 0; k < 200 && !m_tvalid[0]; k++) @(negedge aclk);
        if (k == 200) timeout("stall_valid");
        for (int c = 0; c < 10; c++) begin
          @(negedge aclk);
          #1;
          chk($sformatf("stall_srdy%0d", c), 129'(s_tready[0]), 129'd0);
          chk($sformatf("stall_data%0d", c), {m_tvalid[0], m_tlast[0], m_tdata[0]} & 129'h1_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF,
              {1'b0, 128'h000102030405060708090A0B0C0D0E0F});
        end
        @(negedge aclk);
        m_tready[0] = 1'b1;
      end
    join
    wait_blocks(0, 2);
    repeat (2) @(negedge aclk);
    #1;
    exp_cnt[0] += 2;
    chk("stall_nblk", 129'(q0.size()), 129'd2);
    chk("stall_blk0", q0[0], {1'b0, 128'h000102030405060708090A0B0C0D0E0F});
    chk("stall_blk1", q0[1], {1'b1, 128'h101112131415161718191A1B1C1D1E1F});
    chk("stall_cnt", 129'(bo[0]), 129'(exp_cnt[0]));

    qclear(0);
    send_msg(0, 48, 8'h40, 8'h01, 1'b1, st);
    wait_blocks(0, 3);
    repeat (2) @(negedge aclk);
    #1;
    exp_cnt[0] += 3;
    chk("burst_stalls", 129'(st), 129'd0);
    chk("burst_nblk", 129'(q0.size()), 129'd3);
    chk("burst_blk0", q0[0], {1'b0, 128'h404142434445464748494A4B4C4D4E4F});
    chk("burst_blk1", q0[1], {1'b0, 128'h505152535455565758595A5B5C5D5E5F});
    chk("burst_blk2", q0[2], {1'b1, 128'h606162636465666768696A6B6C6D6E6F});
    chk("burst_gap1", 129'(t0[1] - t0[0]), 129'd16);
    chk("burst_gap2", 129'(t0[2] - t0[1]), 129'd16);
    chk("burst_cnt", 129'(bo[0]), 129'(exp_cnt[0]));

    @(negedge aclk);
    m_tready[0] = 1'b0;
    send_msg(0, 16, 8'hC0, 8'h01, 1'b1, st);
    send_msg(1, 7, 8'h70, 8'h01, 1'b0, st);
    #1;
    chk("pre_rst_valid0", 129'(m_tvalid[0]), 129'd1);
    chk("pre_rst_idx1", 129'(bidx[1]), 129'd7);
    @(negedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    chk_reset("arst");
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    @(negedge aclk);
    aresetn = 1'b1;
    m_tready[0] = 1'b1;
    qclear(1);
    send_msg(1, 16, 8'h90, 8'h01, 1'b1, st);
    wait_blocks(1, 2);
    repeat (2) @(negedge aclk);
    #1;
    chk("fresh_blk0", q1[0], {1'b0, 128'h909192939495969798999A9B9C9D9E9F});
    chk("fresh_blk1", q1[1], {1'b1, 128'h10101010101010101010101010101010});
    chk("fresh_cnt", 129'(bo[1]), 129'd2);
    chk("fresh_cnt0", 129'(bo[0]), 129'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
